// File: rtl/countdown_timer.sv
// countdown_timer: loadable saturating down-counter with a one-cycle completion pulse.
// Once loaded it counts down to zero, pulses done for one cycle, then idles.
//
// Ports:
//   clk       system clock, rising edge
//   reset     synchronous active-high reset, highest priority
//   load      load strobe; samples load_val on the rising edge
//   load_val  start value for the countdown
//   satEn     count enable; decrement once per cycle while running
//   val_out   current count (registered)
//   busy      high while counting (RUN)
//   done      one-cycle completion pulse (DONE)
//   zero      registered flag, high whenever val_out == 0
module countdown_timer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             satEn,
  output logic [WIDTH-1:0] val_out,
  output logic             busy,
  output logic             done,
  output logic             zero
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [WIDTH-1:0] One = WIDTH'(1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] val_q, val_d;
  logic             zero_q;

  always_comb begin
    state_d = state_q;
    val_d   = val_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (load) begin
          // A load during DONE restarts with no idle cycle in between.
          val_d   = load_val;
          state_d = (load_val == '0) ? StDone : StRun;
        end else begin
          // IDLE ignores satEn, so the count can never wrap below zero.
          val_d   = '0;
          state_d = StIdle;
        end
      end
      StRun: begin
        if (load) begin
          val_d   = load_val;
          state_d = (load_val == '0) ? StDone : StRun;
        end else if (satEn) begin
          if (val_q > One) begin
            val_d = val_q - One;
          end else begin
            // Reaching zero ends the run; also guards against a stray 0 in RUN.
            val_d   = '0;
            state_d = StDone;
          end
        end
      end
      default: begin
        val_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      val_q   <= '0;
      zero_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      val_q   <= val_d;
      // zero is registered alongside the count rather than decoded from it.
      zero_q  <= (val_d == '0);
    end
  end

  assign val_out = val_q;
  assign busy    = (state_q == StRun);
  assign done    = (state_q == StDone);
  assign zero    = zero_q;

endmodule
